serial_fa_sequencer: RTL and testbench

- Bit-serial adder controller that sits directly upstream and downstream of the team's single-bit, decoder-based full-adder cell.
- On each cycle it feeds the cell one operand bit pair plus the stored carry, then captures the cell's sum and carry-out.
- A WIDTH-bit addition completes over WIDTH cycles behind a start/busy/done handshake.
- The full-adder cell is instantiated outside this block; it connects through the fa_* ports.

---
 rtl/serial_fa_sequencer.sv | 119 +++++++++++
 tb/tb_serial_fa_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_fa_sequencer.sv
// Bit-serial adder controller wrapped around an external single-bit full-adder cell.
// One operand bit pair is added per cycle, LSB first; results appear behind a start/busy/done handshake.
module serial_fa_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_ca,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Only the upper WIDTH-1 sum bits need to be carried between cycles;
    // the newest bit always comes straight from the cell.
    logic [WIDTH-2:0] sum_sh;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] sum_next;
    logic             accept;
    logic             last_bit;

    assign sum_next = {fa_s, sum_sh};
    assign accept   = (state == S_IDLE) && start;
    assign last_bit = (state == S_SHIFT) && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        fa_a       = 1'b0;
        fa_b       = 1'b0;
        fa_cin     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy   = 1'b1;
                fa_a   = a_sh[0];
                fa_b   = b_sh[0];
                fa_cin = carry_q;
                if (cnt == LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand shifters, carry, counter and held results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            a_sh    <= a_in;
            b_sh    <= b_in;
            carry_q <= cin_in;
            cnt     <= '0;
        end else if (state == S_SHIFT) begin
            a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh  <= sum_next[WIDTH-1:1];
            carry_q <= fa_ca;
            cnt     <= cnt + 1'b1;
            if (last_bit) begin
                sum_out <= sum_next;
                cout    <= fa_ca;
            end
        end
    end

endmodule

// File: tb/tb_serial_fa_sequencer.sv
// Self-checking bench for serial_fa_sequencer with a behavioural full-adder cell
// and a queue of expected {cout, sum} results popped on every done pulse.
module tb_serial_fa_sequencer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_s;
    logic         fa_ca;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;

    int total  = 0;
    int passed = 0;
    int done_count = 0;
    logic [W:0] exp_q[$];

    serial_fa_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin_in  (cin_in),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_s    (fa_s),
        .fa_ca   (fa_ca),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
    );

    // Behavioural stand-in for the external full-adder cell.
    assign fa_s  = fa_a ^ fa_b ^ fa_cin;
    assign fa_ca = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            logic [W:0] e;
            done_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum_out", 32'(sum_out), 32'(e[W-1:0]));
                check("cout", 32'(cout), 32'(e[W]));
            end
        end
    end

    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input bit inject);
        logic [W:0] e;
        int cyc;
        int busy_cyc;
        e = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        @(negedge clk);
        check("fa_idle", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        a_in   = a;
        b_in   = b;
        cin_in = c;
        start  = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        start = 1'b0;
        check("fa_first", 32'({fa_a, fa_b, fa_cin}), 32'({a[0], b[0], c}));
        cyc = 0;
        busy_cyc = 0;
        while (!done && cyc < 3*W) begin
            if (busy) busy_cyc++;
            if (inject && cyc == 2) begin
                @(negedge clk);
                start = 1'b1;
                a_in  = 8'hAA;
                b_in  = 8'h55;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check("done_latency", 32'(cyc), 32'(W));
        check("busy_cycles", 32'(busy_cyc), 32'(W));
        check("busy_in_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("idle_after", 32'({busy, done}), 32'd0);
    endtask

    initial begin
        int dc;
        int nd;
        int cyc;
        int dt[3];

        rst    = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_add(8'h0F, 8'h01, 1'b0, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0, 1'b0);

        dc = done_count;
        run_add(8'h12, 8'h34, 1'b0, 1'b1);
        repeat (12) @(posedge clk);
        check("ignored_start_one_done", 32'(done_count - dc), 32'd1);

        run_add(8'hFF, 8'hFF, 1'b1, 1'b0);

        // Abort an addition with an asynchronous mid-cycle reset.
        @(negedge clk);
        a_in   = 8'h11;
        b_in   = 8'h22;
        cin_in = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum_out), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        dc = done_count;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_count - dc), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        run_add(8'h01, 8'h01, 1'b0, 1'b0);

        // Back-to-back: start held high.
        @(negedge clk);
        a_in   = 8'h80;
        b_in   = 8'h80;
        cin_in = 1'b0;
        start  = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(9'h100);
        nd  = 0;
        cyc = 0;
        while (nd < 3 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                dt[nd] = cyc;
                nd++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b_count", 32'(nd), 32'd3);
        if (nd == 3) begin
            check("b2b_first", 32'(dt[0]), 32'(W + 1));
            check("b2b_gap1", 32'(dt[1] - dt[0]), 32'(W + 2));
            check("b2b_gap2", 32'(dt[2] - dt[1]), 32'(W + 2));
        end
        repeat (15) @(posedge clk);
        #1;
        check("b2b_idle", 32'(busy), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
